// File: rtl/gesture_dispatch_if.sv
// Sensor-code input and event/flag outputs of gesture_dispatch.
// master = sensor/driver side, slave = dispatcher.
`timescale 1ns/1ps
interface gesture_dispatch_if #(
  parameter int unsigned GEST_W = 8,
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned IDX_W  = 2
);
  logic [GEST_W-1:0]       data;
  logic                    clr;
  logic [CH_NUM-1:0]       flag;
  logic                    evt_pulse;
  logic [IDX_W-1:0]        evt_idx;
  logic [CH_NUM*CNT_W-1:0] evt_cnt;
  logic                    busy;

  modport master (
    output data, clr,
    input  flag, evt_pulse, evt_idx, evt_cnt, busy
  );

  modport slave (
    input  data, clr,
    output flag, evt_pulse, evt_idx, evt_cnt, busy
  );
endinterface

// File: rtl/gesture_dispatch.sv
// Gesture qualifier/dispatcher: debounces a one-hot sensor code, fires one event per press,
// latches a timed flag and keeps saturating per-channel counts. GEST_AUTOREPEAT_EN re-fires held gestures.
`timescale 1ns/1ps
module gesture_dispatch #(
  parameter int unsigned GEST_W     = 8,
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned STABLE_CNT = 1000,
  parameter int unsigned HOLD_MAX   = 50_000_000,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned IDX_W      = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  gesture_dispatch_if.slave bus
);

  localparam int unsigned STAB_W    = $clog2(STABLE_CNT + 1);
  localparam int unsigned HOLD_W    = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
  localparam int unsigned HOLD_LAST = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
`ifdef GEST_AUTOREPEAT_EN
  localparam int unsigned REP_N     = 16 * STABLE_CNT;
  localparam int unsigned REP_W     = $clog2(REP_N);
`endif

  typedef enum logic [1:0] {IDLE, QUAL, FIRE, WAIT_REL} state_e;

  state_e                        state_q, state_d;
  logic [CH_NUM-1:0]             cand_q, cand_d;
  logic [STAB_W-1:0]             stab_q, stab_d;
  logic [HOLD_W-1:0]             hold_q, hold_d;
  logic [CH_NUM-1:0]             flag_q, flag_d;
  logic                          pulse_q, pulse_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CH_NUM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                          busy_q, busy_d;
`ifdef GEST_AUTOREPEAT_EN
  logic [REP_W-1:0]              rep_q, rep_d;
`endif

  logic [CH_NUM-1:0] code_c;
  logic              valid_c;
  logic [IDX_W-1:0]  cand_idx_c;

  assign code_c  = bus.data[CH_NUM-1:0];
  assign valid_c = (code_c != '0) && ((code_c & (code_c - CH_NUM'(1))) == '0);

  // Upper sensor bits carry no gesture information.
  generate
    if (GEST_W > CH_NUM) begin : g_hi_data
      logic unused_hi_data;
      assign unused_hi_data = ^bus.data[GEST_W-1:CH_NUM];
    end
  endgenerate

  always_comb begin
    cand_idx_c = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (cand_q[i]) cand_idx_c = IDX_W'(i);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef GEST_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif

    case (state_q)
      IDLE: begin
        if (valid_c) begin
          cand_d  = code_c;
          stab_d  = STAB_W'(1);
          state_d = (STABLE_CNT == 1) ? FIRE : QUAL;
        end
      end
      QUAL: begin
        if (code_c == cand_q) begin
          stab_d = stab_q + STAB_W'(1);
          if (stab_q == STAB_W'(STABLE_CNT - 1)) state_d = FIRE;
        end else if (valid_c) begin
          cand_d = code_c;
          stab_d = STAB_W'(1);
        end else begin
          stab_d  = '0;
          state_d = IDLE;
        end
      end
      FIRE: begin
        stab_d  = '0;
        state_d = WAIT_REL;
`ifdef GEST_AUTOREPEAT_EN
        rep_d   = '0;
`endif
      end
      WAIT_REL: begin
        if (code_c != cand_q) begin
          state_d = IDLE;
        end
`ifdef GEST_AUTOREPEAT_EN
        else if (rep_q == REP_W'(REP_N - 2)) begin
          rep_d   = '0;
          state_d = FIRE;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Flag lifetime; a fire in the expiry cycle overrides the clear.
    if ((HOLD_MAX != 0) && (flag_q != '0)) begin
      if (hold_q == HOLD_W'(HOLD_LAST)) begin
        flag_d = '0;
        hold_d = '0;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end else begin
      hold_d = '0;
    end

    if (state_q == FIRE) begin
      flag_d  = cand_q;
      hold_d  = '0;
      pulse_d = 1'b1;
      idx_d   = cand_idx_c;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (cand_q[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    if (bus.clr) begin
      state_d = IDLE;
      cand_d  = '0;
      stab_d  = '0;
      hold_d  = '0;
      flag_d  = '0;
      pulse_d = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
`ifdef GEST_AUTOREPEAT_EN
      rep_d   = '0;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      stab_q  <= '0;
      hold_q  <= '0;
      flag_q  <= '0;
      pulse_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
`ifdef GEST_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
`ifdef GEST_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign bus.flag      = flag_q;
  assign bus.evt_pulse = pulse_q;
  assign bus.evt_idx   = idx_q;
  assign bus.evt_cnt   = cnt_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gesture_dispatch.sv
// Self-checking bench for gesture_dispatch: directed scenarios plus random codes against
// a cycle-level reference model built from press/hold/release rules.
`timescale 1ns/1ps
module tb_gesture_dispatch;

  localparam int S    = 4;
  localparam int HM   = 20;
  localparam int CMAX = 3;

  logic sys_clk;
  logic sys_rst_n;

  gesture_dispatch_if #(.GEST_W(8), .CH_NUM(4), .CNT_W(2), .IDX_W(2)) bus ();

  gesture_dispatch #(
    .GEST_W(8), .CH_NUM(4), .STABLE_CNT(S), .HOLD_MAX(HM), .CNT_W(2), .IDX_W(2)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int pulses[$];

  // Reference model state.
  logic [3:0] m_cand;
  int         m_streak;
  bit         m_fire;
  bit         m_latched;
  int         m_rep;
  logic [3:0] m_flag;
  bit         m_pulse;
  int         m_idx;
  int         m_cnt[4];
  int         m_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cand = '0; m_streak = 0; m_fire = 0; m_latched = 0; m_rep = 0;
    m_flag = '0; m_pulse = 0; m_idx = 0; m_age = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // One clock edge of the model with the sampled inputs.
  task automatic model_edge(input logic [7:0] d, input bit c);
    logic [3:0] code;
    code    = d[3:0];
    m_pulse = 0;
    if (c) begin
      model_reset();
    end else begin
      if (m_flag != 0) begin
        m_age++;
        if (m_age == HM) begin m_flag = '0; m_age = 0; end
      end
      if (m_fire) begin
        m_fire    = 0;
        m_pulse   = 1;
        m_flag    = m_cand;
        m_age     = 0;
        for (int i = 0; i < 4; i++) if (m_cand[i]) m_idx = i;
        if (m_cnt[m_idx] < CMAX) m_cnt[m_idx]++;
        m_latched = 1;
        m_rep     = 0;
      end else if (m_latched) begin
        if (code == m_cand) begin
`ifdef GEST_AUTOREPEAT_EN
          m_rep++;
          if (m_rep == 16 * S - 1) begin m_fire = 1; m_rep = 0; end
`endif
        end else begin
          m_latched = 0;
        end
      end else if ($countones(code) == 1) begin
        if (m_streak > 0 && code == m_cand) m_streak++;
        else begin m_cand = code; m_streak = 1; end
        if (m_streak == S) begin m_fire = 1; m_streak = 0; end
      end else begin
        m_streak = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] ecnt;
    for (int i = 0; i < 4; i++) ecnt[i*2 +: 2] = 2'(m_cnt[i]);
    chk("flag",  32'(bus.flag),      32'(m_flag));
    chk("pulse", 32'(bus.evt_pulse), 32'(m_pulse));
    chk("idx",   32'(bus.evt_idx),   32'(m_idx));
    chk("cnt",   32'(bus.evt_cnt),   32'(ecnt));
    chk("busy",  32'(bus.busy),      32'(m_fire || m_latched || (m_streak > 0)));
  endtask

  task automatic step(input logic [7:0] d, input bit c);
    @(negedge sys_clk);
    bus.data = d;
    bus.clr  = c;
    @(posedge sys_clk);
    cyc++;
    model_edge(d, c);
    #1;
    check_outputs();
    if (bus.evt_pulse) pulses.push_back(cyc);
  endtask

  function automatic int first_pulse();
    return (pulses.size() > 0) ? pulses[0] : -1;
  endfunction

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0);
  endtask

  // Accept a code, release to zero, report when the flag drops.
  task automatic timeout_run(input logic [7:0] code, input string tag);
    int t0;
    int clr_at;
    idle_steps(3);
    pulses.delete();
    t0 = cyc;
    for (int i = 0; i < 6; i++) step(code, 1'b0);
    clr_at = -1;
    for (int i = 0; i < 25; i++) begin
      step(8'h00, 1'b0);
      if (bus.flag == 0 && clr_at < 0) clr_at = cyc;
    end
    chk({tag, "_pulse_at"}, 32'(first_pulse()), 32'(t0 + 5));
    chk({tag, "_clear_at"}, 32'(clr_at), 32'(t0 + 5 + HM));
    chk({tag, "_idx_kept"}, 32'(bus.evt_idx), 32'd0);
  endtask

  initial begin
    int t0;
    int sat_exp[4];
    sat_exp = '{1, 2, 3, 3};
    sys_clk   = 1'b0;
    sys_rst_n = 1'b0;
    bus.data  = '0;
    bus.clr   = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle_steps(2);

    // Clean accept of channel 1.
    pulses.delete();
    t0 = cyc;
    for (int i = 0; i < 10; i++) step(8'h02, 1'b0);
    chk("accept_npulse", 32'(pulses.size()), 32'd1);
    chk("accept_at",     32'(first_pulse()), 32'(t0 + 5));
    chk("accept_idx",    32'(bus.evt_idx),   32'd1);
    chk("accept_flag",   32'(bus.flag),      32'h2);
    chk("accept_cnt1",   32'(bus.evt_cnt[3:2]), 32'd1);

    // Short glitch and a multi-bit code: neither fires.
    idle_steps(2);
    pulses.delete();
    for (int i = 0; i < 3; i++) step(8'h04, 1'b0);
    idle_steps(2);
    for (int i = 0; i < 10; i++) step(8'h03, 1'b0);
    chk("glitch_npulse", 32'(pulses.size()), 32'd0);

    // Saturating counter on channel 3.
    step(8'h00, 1'b1);
    pulses.delete();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6; i++) step(8'h08, 1'b0);
      chk("sat_cnt3", 32'(bus.evt_cnt[7:6]), 32'(sat_exp[k]));
      idle_steps(3);
    end
    chk("sat_npulse", 32'(pulses.size()), 32'd4);

    // Flag timeout; upper data bits must not matter.
    timeout_run(8'h01, "tmo");
    timeout_run(8'h11, "tmo_hi");

    // clr in the FIRE cycle wins.
    idle_steps(2);
    pulses.delete();
    for (int i = 0; i < 4; i++) step(8'h02, 1'b0);
    step(8'h02, 1'b1);
    chk("clr_pulse", 32'(bus.evt_pulse), 32'd0);
    chk("clr_flag",  32'(bus.flag),      32'd0);
    chk("clr_cnt",   32'(bus.evt_cnt),   32'd0);
    idle_steps(3);
    chk("clr_npulse", 32'(pulses.size()), 32'd0);

    // Asynchronous reset in the middle of qualification.
    for (int i = 0; i < 6; i++) step(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h04, 1'b0);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge sys_clk);
    bus.data  = '0;
    sys_rst_n = 1'b1;
    idle_steps(2);

    // Held gesture: one event, or a repeat every 16*S cycles with auto-repeat.
    pulses.delete();
    t0 = cyc;
    for (int i = 0; i < 200; i++) step(8'h01, 1'b0);
`ifdef GEST_AUTOREPEAT_EN
    chk("rep_npulse", 32'(pulses.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("rep_at", 32'((pulses.size() > k) ? pulses[k] : -1), 32'(t0 + 5 + 64 * k));
`else
    chk("hold_npulse", 32'(pulses.size()), 32'd1);
    chk("hold_at",     32'(first_pulse()), 32'(t0 + 5));
`endif
    idle_steps(2);

    // Random code runs with occasional clr.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] d;
      int pick;
      int len;
      pick = $urandom_range(0, 7);
      len  = $urandom_range(1, 30);
      case (pick)
        0:       d = 8'h00;
        1, 2, 3, 4: d = 8'(1 << (pick - 1));
        5:       d = 8'($urandom);
        6:       d = 8'(1 << $urandom_range(0, 3)) | (8'($urandom) & 8'hF0);
        default: d = 8'h03 << $urandom_range(0, 2);
      endcase
      for (int j = 0; j < len; j++) step(d, $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gesture_dispatch.md
Name: gesture_dispatch

Overview:
Parametrised gesture-event qualifier and dispatcher placed between the PAJ7620 gesture reader and the output drivers (buzzer, segment display, LEDs). It decodes a one-hot gesture code from the sensor data bus and requires the code to be stable before accepting it. On acceptance it latches a one-hot channel flag, emits a single event pulse with a channel index, and keeps saturating per-channel event counts. Flags auto-clear after a programmable hold time.

Parameters:
GEST_W, 8, width of incoming sensor data bus
CH_NUM, 4, number of decoded gesture channels (1..GEST_W); bits data[CH_NUM-1:0] are decoded
STABLE_CNT, 1000, consecutive cycles a code must stay valid and unchanged before acceptance (>=1)
HOLD_MAX, 50_000_000, cycles a latched flag survives without a new event; 0 = hold forever
CNT_W, 8, width of each per-channel saturating event counter
IDX_W, 2, width of evt_idx (>= clog2(CH_NUM), min 1)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
data  in  GEST_W  gesture code from sensor reader, sys_clk domain
clr  in  1  synchronous clear of flags, counters and FSM
flag  out  CH_NUM  latched one-hot active gesture, 0 = none
evt_pulse  out  1  one-cycle strobe on each accepted event
evt_idx  out  IDX_W  channel index of the last accepted event
evt_cnt  out  CH_NUM*CNT_W  per-channel counters; channel i occupies [i*CNT_W +: CNT_W]
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk. Under reset: flag=0, evt_pulse=0, evt_idx=0, evt_cnt=0, busy=0, FSM=IDLE, stability and hold timers=0.
- Valid candidate: data[CH_NUM-1:0] contains exactly one set bit. data[GEST_W-1:CH_NUM] is ignored. All-zero and multi-bit codes are invalid.
- FSM states: IDLE, QUAL, FIRE, WAIT_REL.
- IDLE: on a valid candidate, capture it into cand, set stab_cnt=1, go to QUAL.
- QUAL: if data[CH_NUM-1:0] equals cand, increment stab_cnt. On reaching STABLE_CNT, go to FIRE. If the code changes, capture the new valid code with stab_cnt=1 (stay in QUAL), or go to IDLE if the new code is invalid.
- With STABLE_CNT=1, IDLE goes directly to FIRE.
- FIRE (one cycle): flag<=cand, evt_pulse=1, evt_idx<=bit position of cand, matching counter +1 saturating at 2^CNT_W-1, hold timer<=0. Next state is WAIT_REL.
- Latency: a clean code arriving at cycle t gives evt_pulse in cycle t+STABLE_CNT+1.
- WAIT_REL: stay while data[CH_NUM-1:0]==cand, so a held gesture counts once. Otherwise go to IDLE; the new code is evaluated from IDLE on the next cycle.
- Hold timer: runs while flag!=0 and HOLD_MAX!=0. When it reaches HOLD_MAX-1, flag<=0 on the next edge. A new FIRE in that same cycle wins: flag is loaded and the timer restarts. The timeout clears only flag; evt_idx and the counters are untouched.
- clr=1: flag, evt_cnt, timers, evt_pulse and evt_idx go to 0 and the FSM goes to IDLE the next cycle. clr has priority over FIRE and the timeout.
- Counters never wrap. evt_pulse is never high for two consecutive cycles.

Optional Feature:
GEST_AUTOREPEAT_EN:
- Defined: in WAIT_REL, if the same code stays held for 16*STABLE_CNT cycles, FSM re-enters FIRE: another pulse, counter +1, hold timer restart. This repeats every 16*STABLE_CNT cycles while the gesture is held.
- Undefined: a held code produces exactly one event, and the repeat counter logic is absent.

Test Plan:
Bench parameters for all scenarios: CH_NUM=4, STABLE_CNT=4, HOLD_MAX=20, CNT_W=2.
- Reset mid-QUAL: assert sys_rst_n=0 asynchronously -> all outputs 0 immediately, busy=0.
- Clean accept: data=8'h02 held 10 cycles from t0 -> single evt_pulse at t0+5, evt_idx=1, flag=4'b0010, evt_cnt ch1=1.
- Glitch reject: data=8'h04 for 3 cycles, then 8'h00 -> no pulse, flag unchanged. Also data=8'h03 held 10 cycles -> no pulse (multi-bit code).
- Saturation: four separate 6-cycle presses of 8'h08 separated by 8'h00 -> ch3 counter reads 1,2,3,3, with four pulses.
- Timeout vs. re-arm: accept 8'h01, hold data=0 -> flag clears exactly 20 cycles after the pulse. Repeat the test with 8'h10 also set (data=8'h11) -> identical result, upper bits ignored.
- clr collision: assert clr in the FIRE cycle -> no pulse, flag=0, counters 0. With GEST_AUTOREPEAT_EN defined, hold 8'h01 for 200 cycles -> pulses at t0+5, +69, +133, +197.
